// File: rtl/vga_pkg.sv
// vga_pkg: shared frame geometry defaults and address generator state encoding
package vga_pkg;
    localparam int H_PIXELS = 320;
    localparam int V_LINES  = 240;
    localparam int N        = H_PIXELS * V_LINES;
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;
endpackage

// File: rtl/address_generator_pixel_counter.sv
// pixel_counter: column/row position counters with end-of-line and end-of-frame wrap flags
module pixel_counter #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic col_wrap_o,
    output logic row_wrap_o
);
    localparam int CW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int RW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    assign col_wrap_o = (col_q == CW'(H_PIXELS - 1));
    assign row_wrap_o = (row_q == RW'(V_LINES - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            col_d = col_wrap_o ? '0 : col_q + CW'(1);
            row_d = !col_wrap_o ? row_q : (row_wrap_o ? '0 : row_q + RW'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/address_generator.sv
// address_generator: streams row-major frame-buffer read addresses with start/end-of-packet flags
module address_generator #(
    parameter int H_PIXELS = vga_pkg::H_PIXELS,
    parameter int V_LINES  = vga_pkg::V_LINES,
    parameter int ADDR_W   = 17
) (
    input  logic              clk_25_vga,
    input  logic              reset_n,
    input  logic              resend,
    input  logic              vga_ready,
    output logic              vga_start_out,
    output logic              vga_end_out,
    output logic [ADDR_W-1:0] rdaddress
);
    import vga_pkg::*;

    localparam int N_PIX = H_PIXELS * V_LINES;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              active, consume, col_wrap, row_wrap;

    assign active  = (state_q == ACTIVE);
    assign consume = active && vga_ready && !resend;

    pixel_counter #(
        .H_PIXELS(H_PIXELS),
        .V_LINES (V_LINES)
    ) u_pc (
        .clk_i     (clk_25_vga),
        .rst_ni    (reset_n),
        .clr_i     (!active || resend),
        .inc_i     (consume),
        .col_wrap_o(col_wrap),
        .row_wrap_o(row_wrap)
    );

    // The frame wrap comes from the position counters, so rdaddress never relies on overflow
    always_comb begin
        state_d = resend ? IDLE : ACTIVE;
        addr_d  = addr_q;
        if (resend || !active)
            addr_d = '0;
        else if (vga_ready)
            addr_d = (col_wrap && row_wrap) ? '0 : addr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk_25_vga or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign rdaddress     = addr_q;
    assign vga_start_out = active && (addr_q == '0);
    assign vga_end_out   = active && (addr_q == ADDR_W'(N_PIX - 1));
endmodule

// File: tb/tb_address_generator.sv
// tb_address_generator: directed and random stimulus checked against a frame-position reference model
module tb_address_generator;
    localparam int H = 320;
    localparam int V = 240;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        resend = 1'b1;
    logic        vga_ready = 1'b0;
    logic        vga_start_out, vga_end_out;
    logic [16:0] rdaddress;

    int total = 0;
    int fails = 0;
    bit m_active = 1'b0;
    int m_addr = 0;

    always #20 clk = ~clk;

    address_generator dut (
        .clk_25_vga   (clk),
        .reset_n      (reset_n),
        .resend       (resend),
        .vga_ready    (vga_ready),
        .vga_start_out(vga_start_out),
        .vga_end_out  (vga_end_out),
        .rdaddress    (rdaddress)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  int'(rdaddress), m_addr);
        chk({tag, ".start"}, int'(vga_start_out), int'(m_active && m_addr == 0));
        chk({tag, ".end"},   int'(vga_end_out), int'(m_active && m_addr == N - 1));
        chk({tag, ".col"},   int'(dut.u_pc.col_q), m_addr % H);
        chk({tag, ".row"},   int'(dut.u_pc.row_q), m_addr / H);
        chk({tag, ".state"}, int'(dut.state_q == vga_pkg::ACTIVE), int'(m_active));
    endtask

    task automatic step(input bit rdy, input bit rs);
        vga_ready = rdy;
        resend = rs;
        @(posedge clk);
        if (rs) begin
            m_active = 1'b0;
            m_addr = 0;
        end else if (!m_active)
            m_active = 1'b1;
        else if (rdy)
            m_addr = (m_addr + 1) % N;
        @(negedge clk);
    endtask

    initial begin
        #5;
        check_all("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(0, 1);
        step(0, 1);
        check_all("held_resend");
        step(0, 0);
        check_all("enter_active");
        step(1, 0);
        check_all("first_consume");
        for (int i = 0; i < 4; i++) step(1, 0);
        check_all("four_consumes");
        step(1, 1);
        check_all("resend_pulse");
        step(1, 0);
        check_all("restart_active");
        step(0, 1);
        step(0, 0);
        for (int i = 0; i < N - 1; i++) step(1, 0);
        check_all("last_pixel");
        step(1, 0);
        check_all("frame_wrap");
        step(1, 0);
        check_all("after_wrap");
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
            check_all("random");
        end
        step(0, 1);
        step(0, 0);
        for (int i = 0; i < 500; i++) step(1, 0);
        check_all("at_500");
        step(1, 1);
        check_all("resend_beats_ready");
        step(0, 0);
        for (int i = 0; i < 37; i++) step(1, 0);
        check_all("pre_reset");
        #3 reset_n = 1'b0;
        m_active = 1'b0;
        m_addr = 0;
        #1 check_all("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 0);
        check_all("post_reset_active");
        step(1, 0);
        check_all("post_reset_consume");
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
